axis_spike_detector: RTL and testbench

AXIS_SPIKE_DETECTOR -- requirements
Module: axis_spike_detector

---
 rtl/axis_spike_detector_if.sv | 36 +++
 rtl/axis_spike_detector.sv | 153 +++++++++++++++
 tb/tb_axis_spike_detector.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_spike_detector_if.sv
// Stream bundle for axis_spike_detector: sample input stream (s_axis_a_*) and event output stream (m_axis_b_*).
// The slave modport is the detector's view; the master modport is the view of the surrounding logic.
interface axis_spike_detector_if #(
  parameter int CHANNEL_COUNT = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int TIME_WIDTH    = 32
);
  localparam int CH_W = $clog2(CHANNEL_COUNT);

  logic [CH_W-1:0]              s_axis_a_tchannel;
  logic signed [DATA_WIDTH-1:0] s_axis_a_tdata;
  logic                         s_axis_a_tvalid;
  logic                         s_axis_a_tlast;
  logic                         s_axis_a_tready;

  logic [TIME_WIDTH-1:0]        m_axis_b_time;
  logic [CH_W-1:0]              m_axis_b_tchannel;
  logic [DATA_WIDTH-2:0]        m_axis_b_tdata;
  logic                         m_axis_b_tvalid;
  logic                         m_axis_b_tready;
  logic                         m_axis_b_tlast;

  modport slave (
    input  s_axis_a_tchannel, s_axis_a_tdata, s_axis_a_tvalid, s_axis_a_tlast,
    output s_axis_a_tready,
    output m_axis_b_time, m_axis_b_tchannel, m_axis_b_tdata, m_axis_b_tvalid, m_axis_b_tlast,
    input  m_axis_b_tready
  );

  modport master (
    output s_axis_a_tchannel, s_axis_a_tdata, s_axis_a_tvalid, s_axis_a_tlast,
    input  s_axis_a_tready,
    input  m_axis_b_time, m_axis_b_tchannel, m_axis_b_tdata, m_axis_b_tvalid, m_axis_b_tlast,
    output m_axis_b_tready
  );
endinterface

// File: rtl/axis_spike_detector.sv
// Per-channel threshold spike detector with refractory dead time and a timestamped event FIFO.
// Optional SPIKE_DET_DROP_CNT_EN: saturating 16-bit count of events dropped on a full FIFO.
module axis_spike_detector #(
  parameter int CHANNEL_COUNT = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int TIME_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int REFRACTORY    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_spike_detector_if.slave  bus,
  input  logic [DATA_WIDTH-2:0] threshold,
  output logic                  overflow,
  output logic [15:0]           drop_count
);
  localparam int CH_W  = $clog2(CHANNEL_COUNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REF_W = $clog2(REFRACTORY + 1);
  localparam int MAG_W = DATA_WIDTH - 1;

  typedef struct packed {
    logic [TIME_WIDTH-1:0] ts;
    logic [CH_W-1:0]       ch;
    logic [MAG_W-1:0]      mag;
    logic                  last;
  } event_t;

  logic                  ready_q;
  logic                  accept;
  logic [TIME_WIDTH-1:0] frame_cnt;
  logic [DATA_WIDTH-1:0] neg_data;
  logic [MAG_W-1:0]      in_mag;

  logic                  s1_valid;
  event_t                s1_ev;
  logic [MAG_W-1:0]      s1_thr;
  logic                  ch_ok;
  logic                  detect;
  logic [REF_W-1:0]      refr [CHANNEL_COUNT];

  event_t                mem [FIFO_DEPTH];
  event_t                head;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  fifo_valid, fifo_full, push, pop, drop, wr_en;

  assign bus.s_axis_a_tready = ready_q;
  assign accept = bus.s_axis_a_tvalid && ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // The most-negative sample has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    neg_data = '0 - bus.s_axis_a_tdata;
    in_mag   = '0;
    if (bus.s_axis_a_tdata == {1'b1, {MAG_W{1'b0}}}) in_mag = '1;
    else if (bus.s_axis_a_tdata[DATA_WIDTH-1])       in_mag = neg_data[MAG_W-1:0];
    else                                             in_mag = bus.s_axis_a_tdata[MAG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      s1_valid  <= 1'b0;
      s1_ev     <= '0;
      s1_thr    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ev  <= '{ts: frame_cnt, ch: bus.s_axis_a_tchannel, mag: in_mag,
                    last: bus.s_axis_a_tlast};
        s1_thr <= threshold;
        if (bus.s_axis_a_tlast) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  generate
    if ((1 << CH_W) > CHANNEL_COUNT) begin : g_ch_check
      assign ch_ok = (int'(s1_ev.ch) < CHANNEL_COUNT);
    end else begin : g_ch_full
      assign ch_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    detect = s1_valid && ch_ok && (s1_ev.mag > s1_thr) && (refr[s1_ev.ch] == '0);
  end

  // Every accepted non-detecting beat of a channel burns one tick of its dead time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) refr[i] <= '0;
    end else if (s1_valid && ch_ok) begin
      if (detect)                    refr[s1_ev.ch] <= REF_W'(REFRACTORY);
      else if (refr[s1_ev.ch] != '0) refr[s1_ev.ch] <= refr[s1_ev.ch] - 1'b1;
    end
  end

  assign fifo_valid = (count != '0);
  assign fifo_full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign push       = detect;
  assign pop        = fifo_valid && bus.m_axis_b_tready;
  assign drop       = push && fifo_full && !pop;
  assign wr_en      = push && !drop;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s1_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef SPIKE_DET_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= '0;
    else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 1'b1;
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

  // Gate the head with valid so the bus reads zero when empty or in reset.
  assign bus.m_axis_b_tvalid   = fifo_valid;
  assign bus.m_axis_b_time     = fifo_valid ? head.ts   : '0;
  assign bus.m_axis_b_tchannel = fifo_valid ? head.ch   : '0;
  assign bus.m_axis_b_tdata    = fifo_valid ? head.mag  : '0;
  assign bus.m_axis_b_tlast    = fifo_valid ? head.last : 1'b0;
endmodule

// File: tb/tb_axis_spike_detector.sv
// Bench for axis_spike_detector: directed scenarios plus randomized traffic against a frame/sample-count model.
module tb_axis_spike_detector;
  localparam int CC = 4;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int FD = 16;
  localparam int RF = 8;
  localparam int CW = $clog2(CC);
`ifdef SPIKE_DET_DROP_CNT_EN
  localparam int EXP_DROPS = 4;
`else
  localparam int EXP_DROPS = 0;
`endif

  typedef struct packed {
    logic [TW-1:0] ts;
    logic [CW-1:0] ch;
    logic [DW-2:0] mag;
    logic          last;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-2:0] thr_sig = '0;
  logic          ovf;
  logic [15:0]   dcnt;

  ev_t exp_q[$];
  ev_t got_q[$];
  int  checks = 0;
  int  failures = 0;
  int  frame_no;
  int  seen[CC];
  int  last_det[CC];
  bit  has_det[CC];

  axis_spike_detector_if #(.CHANNEL_COUNT(CC), .DATA_WIDTH(DW), .TIME_WIDTH(TW)) bus ();

  axis_spike_detector #(
    .CHANNEL_COUNT(CC), .DATA_WIDTH(DW), .TIME_WIDTH(TW), .FIFO_DEPTH(FD), .REFRACTORY(RF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .threshold(thr_sig), .overflow(ovf), .drop_count(dcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.m_axis_b_tvalid && bus.m_axis_b_tready)
      got_q.push_back({bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    frame_no = 0;
    for (int i = 0; i < CC; i++) begin
      seen[i] = 0; last_det[i] = 0; has_det[i] = 1'b0;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    bus.s_axis_a_tvalid = 1'b0;
    bus.s_axis_a_tlast  = 1'b0;
    bus.s_axis_a_tdata  = '0;
    bus.s_axis_a_tchannel = '0;
    bus.m_axis_b_tready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Event rule: |x| (clamped) above threshold, and more than RF samples since the channel's last event.
  task automatic drive_beat(input int ch, input int data, input bit last);
    int mag;
    bus.s_axis_a_tchannel = CW'(ch);
    bus.s_axis_a_tdata    = DW'(data);
    bus.s_axis_a_tlast    = last;
    bus.s_axis_a_tvalid   = 1'b1;
    mag = (data < 0) ? -data : data;
    if (mag > 2**(DW-1) - 1) mag = 2**(DW-1) - 1;
    if (mag > int'(thr_sig) && (!has_det[ch] || seen[ch] - last_det[ch] > RF)) begin
      exp_q.push_back({TW'(frame_no), CW'(ch), (DW-1)'(mag), last});
      has_det[ch]  = 1'b1;
      last_det[ch] = seen[ch];
    end
    seen[ch]++;
    if (last) frame_no++;
    step();
    bus.s_axis_a_tvalid = 1'b0;
  endtask

  task automatic drive_frame(input int mask, input int val);
    for (int c = 0; c < CC; c++) drive_beat(c, mask[c] ? val : 0, c == CC - 1);
  endtask

  task automatic drain(input int budget);
    bus.m_axis_b_tready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (got_q.size() >= exp_q.size() && !bus.m_axis_b_tvalid) break;
    end
    step(); step();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_axis_b_tvalid, bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast} !== '0) begin
      failures++; $display("FAIL reset_outputs got tvalid=%b time=%h ch=%h data=%h last=%b required all zero",
        bus.m_axis_b_tvalid, bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast);
    end
    checks++;
    if (bus.s_axis_a_tready !== 1'b0 || ovf !== 1'b0 || dcnt !== 16'd0) begin
      failures++; $display("FAIL reset_flags got tready=%b overflow=%b drop_count=%0d required 0/0/0",
        bus.s_axis_a_tready, ovf, dcnt);
    end
    bus.m_axis_b_tready = 1'b1;
    bus.s_axis_a_tvalid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.s_axis_a_tready !== 1'b1) begin
      failures++; $display("FAIL reset_release_tready got=%b required=1", bus.s_axis_a_tready);
    end
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    thr_sig = 15'd100;
    for (int f = 0; f < 5; f++) drive_frame(0, 0);
    drive_beat(0, 0, 0); drive_beat(1, 0, 0); drive_beat(2, 0, 0); drive_beat(3, -101, 1);
    checks++;
    if (bus.m_axis_b_tvalid !== 1'b0) begin
      failures++; $display("FAIL basic_latency_early got tvalid=%b required=0", bus.m_axis_b_tvalid);
    end
    step();
    checks++;
    if ({bus.m_axis_b_tvalid, bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast}
        !== {1'b1, 4'd5, 2'd3, 15'd101, 1'b1}) begin
      failures++; $display("FAIL basic_event got v=%b t=%0d ch=%0d d=%0d l=%b required v=1 t=5 ch=3 d=101 l=1",
        bus.m_axis_b_tvalid, bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast);
    end
    drain(100);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL basic_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_magnitude();
    do_reset();
    thr_sig = 15'd100;
    drive_beat(0, 0, 0); drive_beat(1, 0, 0); drive_beat(2, 0, 0); drive_beat(3, 100, 1);
    drive_beat(0, 32767, 0); drive_beat(1, -32767, 0); drive_beat(2, 101, 0); drive_beat(3, -32768, 1);
    drain(100);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL mag_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL mag_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 4) begin
      checks++;
      if (got_q[3] !== {4'd1, 2'd3, 15'h7fff, 1'b1}) begin
        failures++; $display("FAIL mag_saturate got=%h required=%h", got_q[3], {4'd1, 2'd3, 15'h7fff, 1'b1});
      end
    end
  endtask

  task automatic test_refractory();
    do_reset();
    thr_sig = 15'd100;
    for (int f = 0; f < 10; f++) drive_frame(4, 500);
    drain(100);
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL refr_count got=%0d required=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].ts !== 4'd0 || got_q[1].ts !== 4'd9) begin
        failures++; $display("FAIL refr_times got=%0d,%0d required=0,9", got_q[0].ts, got_q[1].ts);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL refr_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_threshold_change();
    do_reset();
    thr_sig = 15'd100;
    drive_beat(0, 150, 0);
    thr_sig = 15'd200;
    drive_beat(1, 150, 0);
    thr_sig = 15'd100;
    drive_beat(2, 150, 0);
    thr_sig = 15'd200;
    step(); step();
    drain(100);
    checks++;
    if (got_q.size() != 2 || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL thr_count got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL thr_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    thr_sig = 15'd100;
    bus.m_axis_b_tready = 1'b0;
    for (int f = 0; f < 37; f++) drive_frame(4'hF, 1000);
    step(); step(); step();
    checks++;
    if (ovf !== 1'b1 || dcnt !== 16'(EXP_DROPS)) begin
      failures++; $display("FAIL ovf_flags got overflow=%b drop_count=%0d required 1/%0d", ovf, dcnt, EXP_DROPS);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.m_axis_b_tvalid, bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast}
          !== {1'b1, exp_q[0]}) begin
        failures++; $display("FAIL ovf_head_stable%0d got v=%b ev=%h required v=1 ev=%h", k, bus.m_axis_b_tvalid,
          {bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast}, exp_q[0]);
      end
      step(); step(); step();
    end
    while (exp_q.size() > FD) void'(exp_q.pop_back());
    drain(200);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL ovf_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ovf_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b required=1", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    thr_sig = 15'd100;
    bus.m_axis_b_tready = 1'b0;
    for (int f = 0; f < 36; f++) drive_frame(4'hF, 1000);
    step(); step(); step();
    drive_beat(0, 1000, 0);
    bus.m_axis_b_tready = 1'b1;
    step();
    bus.m_axis_b_tready = 1'b0;
    step(); step(); step();
    checks++;
    if (ovf !== 1'b0 || dcnt !== 16'd0) begin
      failures++; $display("FAIL fullpp_flags got overflow=%b drop_count=%0d required 0/0", ovf, dcnt);
    end
    drain(200);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL fullpp_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL fullpp_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    thr_sig = 15'd100;
    for (int f = 0; f < 16; f++) drive_frame(0, 0);
    drive_frame(2, 200);
    drain(100);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL wrap_count got=%0d required=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {4'd0, 2'd1, 15'd200, 1'b0} || got_q[0] !== exp_q[0]) begin
        failures++; $display("FAIL wrap_event got=%h required=%h", got_q[0], {4'd0, 2'd1, 15'd200, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    thr_sig = 15'd100;
    bus.m_axis_b_tready = 1'b0;
    for (int f = 0; f < 10; f++) drive_frame((f == 0) ? 4'hF : 4'h1, 1000);
    step(); step(); step();
    checks++;
    if (bus.m_axis_b_tvalid !== 1'b1 || exp_q.size() != 5) begin
      failures++; $display("FAIL rstmid_queued got tvalid=%b model=%0d required 1/5", bus.m_axis_b_tvalid, exp_q.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_axis_b_tvalid, bus.m_axis_b_time, bus.m_axis_b_tchannel, bus.m_axis_b_tdata, bus.m_axis_b_tlast,
         bus.s_axis_a_tready} !== '0) begin
      failures++; $display("FAIL rstmid_immediate got tvalid=%b tready=%b required 0/0",
        bus.m_axis_b_tvalid, bus.s_axis_a_tready);
    end
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
    bus.m_axis_b_tready = 1'b1;
    drive_frame(1, 1000);
    drive_frame(0, 0);
    drain(100);
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      failures++; $display("FAIL rstmid_count got=%0d required=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        failures++; $display("FAIL rstmid_event got=%h required=%h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] r;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) thr_sig = 15'($urandom_range(0, 32767));
      bus.m_axis_b_tready = ($urandom % 4) != 0;
      r = 16'($urandom);
      if ($urandom % 4 != 0) begin
        drive_beat(int'($urandom % CC), int'(r), ($urandom % 4) == 0);
      end else begin
        bus.s_axis_a_tdata = r;
        bus.s_axis_a_tlast = $urandom % 2;
        bus.s_axis_a_tvalid = 1'b0;
        step();
      end
    end
    drain(500);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_ev%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL rand_overflow got=%b required=0", ovf);
    end
  endtask

  initial begin
    bus.s_axis_a_tvalid = 1'b0;
    bus.s_axis_a_tlast = 1'b0;
    bus.s_axis_a_tdata = '0;
    bus.s_axis_a_tchannel = '0;
    bus.m_axis_b_tready = 1'b1;
    test_reset();
    test_basic();
    test_magnitude();
    test_refractory();
    test_threshold_change();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
